turf_udp_port_demux: RTL and testbench

TURF_UDP_PORT_DEMUX -- requirements
Module: turf_udp_port_demux

---
 rtl/turf_udp_port_demux.sv | 125 ++++++++++++
 tb/tb_turf_udp_port_demux.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/turf_udp_port_demux.sv
// UDP destination-port demultiplexer.
// Accepts one UDP header at a time, looks up its destination port in PORT_LIST,
// forwards the header and payload to the matching channel, or silently consumes
// the payload and counts a drop when no channel claims the port.
module turf_udp_port_demux #(
    parameter int                          NUM_PORTS      = 4,
    parameter int                          DATA_WIDTH     = 64,
    parameter logic [NUM_PORTS*16-1:0]     PORT_LIST      = {16'd21618, 16'd21603, 16'd21606, 16'd21605},
    parameter int                          DROP_CNT_WIDTH = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,

    input  logic [63:0]                        s_udphdr_tdata,
    input  logic [15:0]                        s_udphdr_tdest,
    input  logic                               s_udphdr_tvalid,
    output logic                               s_udphdr_tready,

    input  logic [DATA_WIDTH-1:0]              s_udpdata_tdata,
    input  logic [DATA_WIDTH/8-1:0]            s_udpdata_tkeep,
    input  logic                               s_udpdata_tlast,
    input  logic                               s_udpdata_tvalid,
    output logic                               s_udpdata_tready,

    output logic [NUM_PORTS*64-1:0]            m_udphdr_tdata,
    output logic [NUM_PORTS-1:0]               m_udphdr_tvalid,
    input  logic [NUM_PORTS-1:0]               m_udphdr_tready,

    output logic [NUM_PORTS*DATA_WIDTH-1:0]    m_udpdata_tdata,
    output logic [NUM_PORTS*DATA_WIDTH/8-1:0]  m_udpdata_tkeep,
    output logic [NUM_PORTS-1:0]               m_udpdata_tlast,
    output logic [NUM_PORTS-1:0]               m_udpdata_tvalid,
    input  logic [NUM_PORTS-1:0]               m_udpdata_tready,

    output logic [DROP_CNT_WIDTH-1:0]          drop_count,
    output logic                               drop_pulse
);

    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int SEL_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    logic [1:0]       state;
    logic [SEL_W-1:0] sel;
    logic [63:0]      hdr_q;
    logic             match;
    logic [SEL_W-1:0] match_idx;
    logic             hdr_fire;
    logic             dat_fire;

    // Port lookup: scan downward so the lowest matching index is the one left standing.
    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (PORT_LIST[16*i +: 16] == s_udphdr_tdest) begin
                match     = 1'b1;
                match_idx = SEL_W'(i);
            end
        end
    end

    // Readies are gated by rst_n so nothing handshakes while reset is held.
    assign s_udphdr_tready  = rst_n && (state == S_IDLE);
    assign s_udpdata_tready = rst_n && (((state == S_DATA) && m_udpdata_tready[sel]) ||
                                        (state == S_DROP));

    assign hdr_fire = s_udphdr_tvalid && s_udphdr_tready;
    assign dat_fire = s_udpdata_tvalid && s_udpdata_tready;

    // Datagram FSM, header latch and drop accounting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            sel        <= '0;
            hdr_q      <= '0;
            drop_count <= '0;
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hdr_fire) begin
                        hdr_q <= s_udphdr_tdata;
                        if (match) begin
                            sel   <= match_idx;
                            state <= S_HDR;
                        end else begin
                            state      <= S_DROP;
                            drop_pulse <= 1'b1;
                            if (drop_count != '1)
                                drop_count <= drop_count + DROP_CNT_WIDTH'(1);
                        end
                    end
                end
                S_HDR: begin
                    if (m_udphdr_tready[sel])
                        state <= S_DATA;
                end
                S_DATA, S_DROP: begin
                    if (dat_fire && s_udpdata_tlast)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Per-channel outputs: data fields broadcast, valids only on the selected channel.
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_ch
        assign m_udphdr_tdata[64*i +: 64]                 = hdr_q;
        assign m_udphdr_tvalid[i]                         = rst_n && (state == S_HDR) &&
                                                            (sel == SEL_W'(i));
        assign m_udpdata_tdata[DATA_WIDTH*i +: DATA_WIDTH] = s_udpdata_tdata;
        assign m_udpdata_tkeep[KEEP_W*i +: KEEP_W]         = s_udpdata_tkeep;
        assign m_udpdata_tlast[i]                         = s_udpdata_tlast;
        assign m_udpdata_tvalid[i]                        = rst_n && (state == S_DATA) &&
                                                            (sel == SEL_W'(i)) && s_udpdata_tvalid;
    end

endmodule

// File: tb/tb_turf_udp_port_demux.sv
// Directed + randomized bench for turf_udp_port_demux with a port-table /
// drop-counter reference model and a beat scoreboard fed by an output monitor.
module tb_turf_udp_port_demux;

    localparam int NP  = 4;
    localparam int DW  = 64;
    localparam int KW  = DW / 8;
    localparam int DCW = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [63:0]        hdr_tdata;
    logic [15:0]        hdr_tdest;
    logic               hdr_tvalid;
    logic               hdr_tready;
    logic [DW-1:0]      d_tdata;
    logic [KW-1:0]      d_tkeep;
    logic               d_tlast;
    logic               d_tvalid;
    logic               d_tready;
    logic [NP*64-1:0]   m_hdr_tdata;
    logic [NP-1:0]      m_hdr_tvalid;
    logic [NP-1:0]      m_hdr_tready;
    logic [NP*DW-1:0]   m_d_tdata;
    logic [NP*KW-1:0]   m_d_tkeep;
    logic [NP-1:0]      m_d_tlast;
    logic [NP-1:0]      m_d_tvalid;
    logic [NP-1:0]      m_d_tready;
    logic [DCW-1:0]     drop_count;
    logic               drop_pulse;

    turf_udp_port_demux #(
        .NUM_PORTS(NP), .DATA_WIDTH(DW), .DROP_CNT_WIDTH(DCW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_udphdr_tdata(hdr_tdata), .s_udphdr_tdest(hdr_tdest),
        .s_udphdr_tvalid(hdr_tvalid), .s_udphdr_tready(hdr_tready),
        .s_udpdata_tdata(d_tdata), .s_udpdata_tkeep(d_tkeep), .s_udpdata_tlast(d_tlast),
        .s_udpdata_tvalid(d_tvalid), .s_udpdata_tready(d_tready),
        .m_udphdr_tdata(m_hdr_tdata), .m_udphdr_tvalid(m_hdr_tvalid), .m_udphdr_tready(m_hdr_tready),
        .m_udpdata_tdata(m_d_tdata), .m_udpdata_tkeep(m_d_tkeep), .m_udpdata_tlast(m_d_tlast),
        .m_udpdata_tvalid(m_d_tvalid), .m_udpdata_tready(m_d_tready),
        .drop_count(drop_count), .drop_pulse(drop_pulse)
    );

    always #5 clk = ~clk;

    // Reference model state: channel table and number of drops since reset.
    int ports[NP] = '{21605, 21606, 21603, 21618};
    int drops = 0;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_tlast_cyc = 0;

    typedef struct {
        int          ch;
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        int          cyc;
    } beat_t;

    beat_t obs_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: every completed payload handshake on any channel.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NP; i++) begin
                if (m_d_tvalid[i] && m_d_tready[i]) begin
                    beat_t b;
                    b.ch   = i;
                    b.data = m_d_tdata[DW*i +: DW];
                    b.keep = m_d_tkeep[KW*i +: KW];
                    b.last = m_d_tlast[i];
                    b.cyc  = cyc;
                    obs_q.push_back(b);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic int exp_chan(input logic [15:0] d);
        for (int i = 0; i < NP; i++)
            if (ports[i] == int'(d)) return i;
        return -1;
    endfunction

    function automatic logic [63:0] exp_drops();
        return (drops > 15) ? 64'd15 : 64'(drops);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One datagram: header, then nb payload beats. tog exercises back-pressure,
    // abort_at >= 0 pulls reset while that beat is presented, chk_gap measures
    // the idle gap since the previous datagram's tlast.
    task automatic send(input logic [15:0] dst, input int nb, input bit tog,
                        input int abort_at, input bit chk_gap);
        int          ch = exp_chan(dst);
        logic [63:0] hdr = {$urandom, $urandom};
        beat_t       exp_q[$];
        beat_t       eb;
        bit          first = 1'b1;
        bit          tgl = 1'b1;
        bit          acc;
        int          w;
        obs_q.delete();
        hdr_tdata    = hdr;
        hdr_tdest    = dst;
        hdr_tvalid   = 1'b1;
        d_tdata      = {$urandom, $urandom};
        d_tkeep      = 8'($urandom);
        d_tlast      = (nb == 1);
        d_tvalid     = 1'b1;
        m_hdr_tready = tog ? '0 : '1;
        m_d_tready   = '1;
        #1;
        chk("hdr_ready_idle", 64'(hdr_tready), 64'd1);
        chk("data_held_idle", 64'(d_tready), 64'd0);
        @(posedge clk); #1;
        hdr_tdata = {$urandom, $urandom};
        hdr_tdest = ~dst;
        #1;
        chk("hdr_ready_busy", 64'(hdr_tready), 64'd0);
        if (ch >= 0) begin
            chk("hdr_valid", 64'(m_hdr_tvalid), 64'(1 << ch));
            chk("hdr_data", m_hdr_tdata[64*ch +: 64], hdr);
            chk("data_held_hdr", 64'(d_tready), 64'd0);
            if (tog) begin
                @(posedge clk); #1;
                m_hdr_tready = '1;
                #1;
                chk("hdr_hold_valid", 64'(m_hdr_tvalid), 64'(1 << ch));
                chk("hdr_hold_data", m_hdr_tdata[64*ch +: 64], hdr);
            end
            @(posedge clk); #1;
        end else begin
            drops++;
            chk("drop_hdr_valid", 64'(m_hdr_tvalid), 64'd0);
            chk("drop_count", 64'(drop_count), exp_drops());
        end
        for (int b = 0; b < nb; b++) begin
            if (b > 0) begin
                d_tdata = {$urandom, $urandom};
                d_tkeep = 8'($urandom);
                d_tlast = (b == nb - 1);
            end
            eb.ch = ch; eb.data = d_tdata; eb.keep = d_tkeep; eb.last = d_tlast; eb.cyc = 0;
            exp_q.push_back(eb);
            if (b == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_d_ready", 64'(d_tready), 64'd0);
                chk("rst_h_ready", 64'(hdr_tready), 64'd0);
                chk("rst_m_dvalid", 64'(m_d_tvalid), 64'd0);
                @(posedge clk); #1;
                drops = 0;
                chk("rst_m_hvalid", 64'(m_hdr_tvalid), 64'd0);
                chk("rst_m_dvalid2", 64'(m_d_tvalid), 64'd0);
                chk("rst_drop_count", 64'(drop_count), 64'd0);
                chk("rst_drop_pulse", 64'(drop_pulse), 64'd0);
                rst_n = 1'b1;
                d_tvalid = 1'b0;
                hdr_tvalid = 1'b0;
                #1;
                chk("rst_release_ready", 64'(hdr_tready), 64'd1);
                return;
            end
            acc = 1'b0;
            for (w = 0; w < 50 && !acc; w++) begin
                if (tog && ch >= 0) begin
                    m_d_tready[ch] = tgl;
                    tgl = ~tgl;
                end
                #1;
                chk("hdr_ready_data", 64'(hdr_tready), 64'd0);
                if (ch >= 0) begin
                    chk("d_valid", 64'(m_d_tvalid), 64'(1 << ch));
                    chk("d_data", m_d_tdata[DW*ch +: DW], d_tdata);
                    chk("d_ready_mirror", 64'(d_tready), 64'(m_d_tready[ch]));
                end else begin
                    chk("drop_d_valid", 64'(m_d_tvalid), 64'd0);
                    chk("drop_d_ready", 64'(d_tready), 64'd1);
                    chk("drop_pulse", 64'(drop_pulse), 64'(first));
                    first = 1'b0;
                end
                acc = d_tready;
                @(posedge clk); #1;
            end
            if (!acc) begin
                chk("beat_timeout", 64'd0, 64'd1);
                d_tvalid = 1'b0;
                hdr_tvalid = 1'b0;
                return;
            end
        end
        d_tvalid = 1'b0;
        m_d_tready = '1;
        if (ch >= 0) begin
            chk("sb_count", 64'(obs_q.size()), 64'(exp_q.size()));
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                chk("sb_ch", 64'(obs_q[i].ch), 64'(exp_q[i].ch));
                chk("sb_data", obs_q[i].data, exp_q[i].data);
                chk("sb_keep", 64'(obs_q[i].keep), 64'(exp_q[i].keep));
                chk("sb_last", 64'(obs_q[i].last), 64'(exp_q[i].last));
            end
            if (chk_gap && obs_q.size() > 0)
                chk("gap_le_2", 64'((obs_q[0].cyc - last_tlast_cyc - 1) <= 2), 64'd1);
            if (obs_q.size() > 0) last_tlast_cyc = obs_q[obs_q.size()-1].cyc;
        end else begin
            chk("drop_no_output", 64'(obs_q.size()), 64'd0);
        end
        #1;
        chk("back_to_idle", 64'(hdr_tready), 64'd1);
        chk("drop_count_end", 64'(drop_count), exp_drops());
        hdr_tvalid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        hdr_tdata = '0; hdr_tdest = '0; hdr_tvalid = 1'b0;
        d_tdata = '0; d_tkeep = '0; d_tlast = 1'b0; d_tvalid = 1'b0;
        m_hdr_tready = '1; m_d_tready = '1;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_h_ready", 64'(hdr_tready), 64'd0);
        chk("reset_d_ready", 64'(d_tready), 64'd0);
        chk("reset_h_valid", 64'(m_hdr_tvalid), 64'd0);
        chk("reset_d_valid", 64'(m_d_tvalid), 64'd0);
        chk("reset_drop_count", 64'(drop_count), 64'd0);
        chk("reset_drop_pulse", 64'(drop_pulse), 64'd0);
        chk("reset_hdr_latch", m_hdr_tdata[63:0], 64'd0);
        rst_n = 1'b1;
        #1;
        chk("release_h_ready", 64'(hdr_tready), 64'd1);

        send(16'd21605, 3, 1'b0, -1, 1'b0);   // channel 0, full throughput
        send(16'd1234,  2, 1'b0, -1, 1'b0);   // unmatched, drop count 0 -> 1
        send(16'd21603, 5, 1'b1, -1, 1'b0);   // channel 2 with toggling ready
        send(16'd21606, 3, 1'b0, -1, 1'b0);   // back-to-back pair
        send(16'd21603, 3, 1'b0, -1, 1'b1);

        for (int k = 0; k < 20; k++)
            send(16'(1000 + k), 1 + (k % 2), 1'b0, -1, 1'b0);
        chk("drop_saturated", 64'(drop_count), 64'd15);

        for (int k = 0; k < 25; k++) begin
            logic [15:0] d;
            d = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'(ports[$urandom_range(0, NP-1)]);
            send(d, $urandom_range(1, 5), 1'($urandom_range(0, 1)), -1, 1'b0);
        end

        send(16'd21605, 4, 1'b0, 1, 1'b0);    // reset while beat 2 of 4 is presented
        send(16'd21618, 3, 1'b0, -1, 1'b0);   // post-reset routes to channel 3

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
